card_dealer: RTL and testbench

//  Shuffled 52-card deck source that sits directly upstream of the game controller.
//  A seeded 6-bit LFSR proposes deck indices, and a 52-bit used-card bitmap rejects repeats.

---
 rtl/card_dealer_if.sv | 27 ++
 rtl/card_dealer.sv | 105 ++++++++++
 tb/tb_card_dealer.sv | 384 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/card_dealer_if.sv
// Signal bundle between the game controller (master) and the card dealer (slave).
// Debug state mirror is carried alongside so checkers can bind without touching internals.
interface card_dealer_if;
    logic [5:0] seed;
    logic       shuffle;
    logic       draw_req;
    logic       card_valid;
    logic [3:0] card_rank;
    logic [5:0] card_index;
    logic       busy;
    logic       deck_empty;
    logic [5:0] cards_left;
    logic       draw_err;
    logic [1:0] dbg_state;

    modport master (
        output seed, shuffle, draw_req,
        input  card_valid, card_rank, card_index, busy, deck_empty, cards_left, draw_err,
        input  dbg_state
    );

    modport slave (
        input  seed, shuffle, draw_req,
        output card_valid, card_rank, card_index, busy, deck_empty, cards_left, draw_err,
        output dbg_state
    );
endinterface

// File: rtl/card_dealer.sv
// Shuffled 52-card deck: a seeded 6-bit LFSR proposes indices, a used-card bitmap
// rejects repeats, and each accepted draw returns one unique card with a valid pulse.
module card_dealer #(
    parameter int         DECK_SIZE = 52,
    parameter logic [5:0] LFSR_INIT = 6'h01
) (
    input logic         clk,
    input logic         rst,
    card_dealer_if.slave dif
);
    // Handshake: shuffle/draw_req are single-cycle request pulses with no back-pressure;
    // a draw_req seen while busy is dropped, card_valid/draw_err are single-cycle replies,
    // and card_rank/card_index hold their value until the next card_valid.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1
    } state_t;

    state_t               state;
    logic [5:0]           lfsr;
    logic [DECK_SIZE-1:0] used;
    logic [5:0]           cards_left;
    logic                 card_valid_r;
    logic                 draw_err_r;
    logic [3:0]           card_rank_r;
    logic [5:0]           card_index_r;

    logic [5:0]           lfsr_next;
    logic [5:0]           cand_idx;
    logic [63:0]          used_pad;
    logic                 cand_ok;
    logic [DECK_SIZE-1:0] hit_mask;
    logic [5:0]           rank_wide;
    logic [3:0]           cand_rank;

    assign lfsr_next = {lfsr[4:0], lfsr[5] ^ lfsr[4]};
    assign cand_idx  = lfsr - 6'd1;
    // Zero-padded view so candidates 52..62 index safely and read as "not free".
    assign used_pad  = 64'(used);
    assign cand_ok   = (cand_idx < 6'(DECK_SIZE)) && !used_pad[cand_idx];
    assign hit_mask  = DECK_SIZE'(64'd1 << cand_idx);

    // Rank = idx mod 13 + 1, done as a compare/subtract chain over the four suits.
    always_comb begin
        rank_wide = 6'd0;
        if (cand_idx < 6'd13)      rank_wide = cand_idx + 6'd1;
        else if (cand_idx < 6'd26) rank_wide = cand_idx - 6'd12;
        else if (cand_idx < 6'd39) rank_wide = cand_idx - 6'd25;
        else                       rank_wide = cand_idx - 6'd38;
        cand_rank = rank_wide[3:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            lfsr         <= LFSR_INIT;
            used         <= '0;
            cards_left   <= 6'(DECK_SIZE);
            card_valid_r <= 1'b0;
            draw_err_r   <= 1'b0;
            card_rank_r  <= 4'd0;
            card_index_r <= 6'd0;
        end else begin
            card_valid_r <= 1'b0;
            draw_err_r   <= 1'b0;
            if (dif.shuffle) begin
                // Shuffle wins over everything, including a search already in flight.
                state      <= IDLE;
                used       <= '0;
                cards_left <= 6'(DECK_SIZE);
                lfsr       <= (dif.seed == 6'd0) ? LFSR_INIT : dif.seed;
            end else begin
                case (state)
                    IDLE: begin
                        if (dif.draw_req) begin
                            if (cards_left == 6'd0) draw_err_r <= 1'b1;
                            else                    state      <= SEARCH;
                        end
                    end
                    SEARCH: begin
                        lfsr <= lfsr_next;
                        if (cand_ok) begin
                            used         <= used | hit_mask;
                            card_index_r <= cand_idx;
                            card_rank_r  <= cand_rank;
                            cards_left   <= cards_left - 6'd1;
                            card_valid_r <= 1'b1;
                            state        <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign dif.card_valid = card_valid_r;
    assign dif.card_rank  = card_rank_r;
    assign dif.card_index = card_index_r;
    assign dif.draw_err   = draw_err_r;
    assign dif.cards_left = cards_left;
    assign dif.deck_empty = (cards_left == 6'd0);
    assign dif.busy       = (state == SEARCH);
    assign dif.dbg_state  = state;
endmodule

// File: tb/tb_card_dealer.sv
// Self-checking bench for card_dealer: reference deck model feeds a scoreboard queue
// that a negedge monitor drains on every card_valid.
module tb_card_dealer;
    logic clk;
    logic rst;
    card_dealer_if dif ();

    card_dealer dut (
        .clk (clk),
        .rst (rst),
        .dif (dif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors;
    int checks;
    int valid_cnt;
    logic [9:0] exp_q[$];

    bit [5:0]  m_lfsr;
    bit [51:0] m_used;
    int        m_left;

    function automatic logic [3:0] f_rank(input logic [5:0] idx);
        int r;
        r = (int'(idx) % 13) + 1;
        return 4'(r);
    endfunction

    task automatic model_shuffle(input logic [5:0] s);
        m_used = '0;
        m_left = 52;
        m_lfsr = (s == 6'd0) ? 6'd1 : s;
    endtask

    task automatic model_pick(output logic [5:0] idx, output int tests);
        bit hit;
        tests = 0;
        hit   = 1'b0;
        idx   = 6'd0;
        while (!hit && tests < 64) begin
            tests++;
            idx = m_lfsr - 6'd1;
            hit = (idx < 6'd52) && !m_used[idx];
            m_lfsr = {m_lfsr[4:0], m_lfsr[5] ^ m_lfsr[4]};
        end
        m_used[idx] = 1'b1;
        m_left--;
    endtask

    always @(negedge clk) begin
        logic [9:0] e;
        if (dif.card_valid === 1'b1) begin
            valid_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_card: got idx=%0d rank=%0d, required no card",
                         dif.card_index, dif.card_rank);
            end else begin
                e = exp_q.pop_front();
                if ({dif.card_rank, dif.card_index} !== e) begin
                    errors++;
                    $display("FAIL card: got rank=%0d idx=%0d, required rank=%0d idx=%0d",
                             dif.card_rank, dif.card_index, e[9:6], e[5:0]);
                end
            end
        end
    end

    task automatic do_shuffle(input logic [5:0] s);
        @(negedge clk);
        dif.seed    = s;
        dif.shuffle = 1'b1;
        @(negedge clk);
        dif.shuffle = 1'b0;
        model_shuffle(s);
    endtask

    task automatic do_draw(output int lat);
        logic [5:0] eidx;
        int tests;
        int pre;
        int busy_cycles;
        bit expect_card;
        lat = 0;
        tests = 0;
        expect_card = (m_left > 0);
        if (expect_card) begin
            model_pick(eidx, tests);
            exp_q.push_back({f_rank(eidx), eidx});
        end
        pre = valid_cnt;
        @(negedge clk);
        dif.draw_req = 1'b1;
        @(negedge clk);
        dif.draw_req = 1'b0;
        #1;
        if (!expect_card) begin
            checks++;
            if (dif.draw_err !== 1'b1) begin
                errors++;
                $display("FAIL draw_err_pulse: got %b, required 1", dif.draw_err);
            end
            @(negedge clk);
            #1;
            checks++;
            if (dif.draw_err !== 1'b0) begin
                errors++;
                $display("FAIL draw_err_width: got %b, required 0", dif.draw_err);
            end
            repeat (3) @(negedge clk);
            #1;
            checks++;
            if (valid_cnt != pre) begin
                errors++;
                $display("FAIL empty_no_card: got %0d cards, required 0", valid_cnt - pre);
            end
        end else begin
            checks++;
            if (dif.busy !== 1'b1) begin
                errors++;
                $display("FAIL busy_start: got %b, required 1", dif.busy);
            end
            busy_cycles = 1;
            for (int k = 1; k <= 70; k++) begin
                @(negedge clk);
                #1;
                if (valid_cnt != pre) begin
                    lat = k;
                    break;
                end
                if (dif.busy === 1'b1) busy_cycles++;
            end
            checks++;
            if (lat != tests) begin
                errors++;
                $display("FAIL latency: got %0d cycles, required %0d", lat, tests);
            end
            checks++;
            if (busy_cycles != tests) begin
                errors++;
                $display("FAIL busy_cycles: got %0d, required %0d", busy_cycles, tests);
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if (dif.card_valid !== 1'b0 || dif.card_rank !== 4'd0 || dif.card_index !== 6'd0 ||
            dif.busy !== 1'b0 || dif.deck_empty !== 1'b0 || dif.cards_left !== 6'd52 ||
            dif.draw_err !== 1'b0 || dif.dbg_state !== 2'd0) begin
            errors++;
            $display("FAIL %s: got v=%b r=%0d i=%0d busy=%b empty=%b left=%0d err=%b st=%0d, required 0s and left=52",
                     tag, dif.card_valid, dif.card_rank, dif.card_index, dif.busy,
                     dif.deck_empty, dif.cards_left, dif.draw_err, dif.dbg_state);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check_reset_outputs("reset_values");
        rst = 1'b0;
        model_shuffle(6'd1);
    endtask

    task automatic test_seed1_sequence();
        logic [5:0] t_idx [6];
        logic [3:0] t_rank[6];
        int lat;
        t_idx  = '{6'd0, 6'd1, 6'd3, 6'd7, 6'd15, 6'd32};
        t_rank = '{4'd1, 4'd2, 4'd4, 4'd8, 4'd3, 4'd7};
        do_shuffle(6'd1);
        for (int i = 0; i < 6; i++) begin
            do_draw(lat);
            checks++;
            if (dif.card_index !== t_idx[i] || dif.card_rank !== t_rank[i] || lat != 1) begin
                errors++;
                $display("FAIL seed1_draw%0d: got idx=%0d rank=%0d lat=%0d, required idx=%0d rank=%0d lat=1",
                         i, dif.card_index, dif.card_rank, lat, t_idx[i], t_rank[i]);
            end
        end
        checks++;
        if (dif.cards_left !== 6'd46) begin
            errors++;
            $display("FAIL seed1_left: got %0d, required 46", dif.cards_left);
        end
    endtask

    task automatic test_rejects();
        int lat;
        do_shuffle(6'd60);
        do_draw(lat);
        checks++;
        if (dif.card_index !== 6'd47 || dif.card_rank !== 4'd9 || lat != 3) begin
            errors++;
            $display("FAIL reject_draw: got idx=%0d rank=%0d lat=%0d, required idx=47 rank=9 lat=3",
                     dif.card_index, dif.card_rank, lat);
        end
    endtask

    task automatic test_full_deck();
        bit [51:0] seen;
        int lat;
        seen = '0;
        do_shuffle(6'd0);
        for (int i = 0; i < 52; i++) begin
            do_draw(lat);
            checks++;
            if (dif.card_index > 6'd51 || seen[dif.card_index] ||
                dif.card_rank !== f_rank(dif.card_index)) begin
                errors++;
                $display("FAIL deck_unique%0d: got idx=%0d rank=%0d, required new idx<52 with rank idx%%13+1",
                         i, dif.card_index, dif.card_rank);
            end else begin
                seen[dif.card_index] = 1'b1;
            end
        end
        checks++;
        if (dif.deck_empty !== 1'b1 || dif.cards_left !== 6'd0) begin
            errors++;
            $display("FAIL deck_empty: got empty=%b left=%0d, required 1 and 0",
                     dif.deck_empty, dif.cards_left);
        end
        do_draw(lat);
    endtask

    task automatic test_shuffle_abort();
        logic [5:0] old_idx;
        int pre;
        int lat;
        old_idx = dif.card_index;
        do_shuffle(6'd60);
        pre = valid_cnt;
        @(negedge clk);
        dif.draw_req = 1'b1;
        @(negedge clk);
        dif.draw_req = 1'b0;
        dif.seed     = 6'd1;
        dif.shuffle  = 1'b1;
        @(negedge clk);
        dif.shuffle  = 1'b0;
        model_shuffle(6'd1);
        repeat (70) @(negedge clk);
        #1;
        checks++;
        if (valid_cnt != pre || dif.busy !== 1'b0 || dif.card_index !== old_idx) begin
            errors++;
            $display("FAIL abort: got cards=%0d busy=%b idx=%0d, required 0 cards busy=0 idx=%0d",
                     valid_cnt - pre, dif.busy, dif.card_index, old_idx);
        end
        do_draw(lat);
        checks++;
        if (dif.card_index !== 6'd0 || dif.card_rank !== 4'd1 || dif.cards_left !== 6'd51) begin
            errors++;
            $display("FAIL after_abort: got idx=%0d rank=%0d left=%0d, required 0 1 51",
                     dif.card_index, dif.card_rank, dif.cards_left);
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] eidx;
        int tests;
        int pre;
        int lat;
        do_shuffle(6'd60);
        model_pick(eidx, tests);
        exp_q.push_back({f_rank(eidx), eidx});
        pre = valid_cnt;
        @(negedge clk);
        dif.draw_req = 1'b1;
        @(negedge clk);
        dif.draw_req = 1'b0;
        @(negedge clk);
        dif.draw_req = 1'b1;
        @(negedge clk);
        dif.draw_req = 1'b0;
        repeat (70) @(negedge clk);
        #1;
        checks++;
        if (valid_cnt != pre + 1 || dif.cards_left !== 6'd51) begin
            errors++;
            $display("FAIL busy_redraw: got cards=%0d left=%0d, required 1 and 51",
                     valid_cnt - pre, dif.cards_left);
        end
        pre = valid_cnt;
        @(negedge clk);
        dif.draw_req = 1'b1;
        dif.seed     = 6'd60;
        dif.shuffle  = 1'b1;
        @(negedge clk);
        dif.draw_req = 1'b0;
        dif.shuffle  = 1'b0;
        model_shuffle(6'd60);
        repeat (10) @(negedge clk);
        #1;
        checks++;
        if (valid_cnt != pre || dif.cards_left !== 6'd52 || dif.busy !== 1'b0) begin
            errors++;
            $display("FAIL shuffle_and_draw: got cards=%0d left=%0d busy=%b, required 0 52 0",
                     valid_cnt - pre, dif.cards_left, dif.busy);
        end
        do_draw(lat);
        checks++;
        if (dif.card_index !== 6'd47 || dif.cards_left !== 6'd51) begin
            errors++;
            $display("FAIL post_coincident: got idx=%0d left=%0d, required 47 51",
                     dif.card_index, dif.cards_left);
        end
    endtask

    task automatic test_reset_mid_search();
        int pre;
        int lat;
        do_shuffle(6'd1);
        for (int i = 0; i < 32; i++) do_draw(lat);
        checks++;
        if (dif.cards_left !== 6'd20) begin
            errors++;
            $display("FAIL pre_reset_left: got %0d, required 20", dif.cards_left);
        end
        pre = valid_cnt;
        @(negedge clk);
        dif.draw_req = 1'b1;
        @(negedge clk);
        dif.draw_req = 1'b0;
        #1;
        checks++;
        if (dif.busy !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_busy: got %b, required 1", dif.busy);
        end
        #1;
        rst = 1'b1;
        #1;
        check_reset_outputs("async_reset");
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        checks++;
        if (valid_cnt != pre) begin
            errors++;
            $display("FAIL reset_no_card: got %0d cards, required 0", valid_cnt - pre);
        end
        do_shuffle(6'd1);
        do_draw(lat);
        checks++;
        if (dif.card_index !== 6'd0 || dif.cards_left !== 6'd51) begin
            errors++;
            $display("FAIL post_reset_draw: got idx=%0d left=%0d, required 0 51",
                     dif.card_index, dif.cards_left);
        end
    endtask

    initial begin
        errors       = 0;
        checks       = 0;
        valid_cnt    = 0;
        rst          = 1'b1;
        dif.seed     = 6'd0;
        dif.shuffle  = 1'b0;
        dif.draw_req = 1'b0;
        test_reset();
        test_seed1_sequence();
        test_rejects();
        test_full_deck();
        test_shuffle_abort();
        test_back_to_back();
        test_reset_mid_search();
        repeat (2) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
